// File: rtl/div_operand_sequencer.sv
// Operand sequencer for the registered 4-bit divider.
// Captures the dividend and then the divisor from a shared switch bus. Each
// capture takes one Load press. The block refuses to launch a divide-by-zero,
// pulses Go for exactly one cycle, and then flags when the divider's
// registered results belong to the current operands.
module div_operand_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Load,
  input  logic             Start,
  output logic [WIDTH-1:0] Dividend,
  output logic [WIDTH-1:0] Divisor,
  output logic             Go,
  output logic             ResultValid,
  output logic             DivByZero,
  output logic             Busy
);

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_WAIT_A,
    S_LOAD_B,
    S_WAIT_B,
    S_READY,
    S_GO,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             go_q, valid_q, dbz_q, busy_q;

  // Next-state and operand-capture decisions.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves a latch behind.
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    case (state_q)
      S_LOAD_A: if (Load) begin
        dividend_d = DataIn;
        state_d    = S_WAIT_A;
      end
      S_WAIT_A: if (!Load) state_d = S_LOAD_B;
      S_LOAD_B: if (Load) begin
        divisor_d = DataIn;
        state_d   = S_WAIT_B;
      end
      S_WAIT_B: if (!Load) state_d = S_READY;
      // Start wins over a simultaneous Load; Load alone does nothing here.
      S_READY: if (Start) state_d = (divisor_q != '0) ? S_GO : S_ERR;
      S_GO:    state_d = S_DONE;
      S_DONE, S_ERR: if (Load) begin
        dividend_d = DataIn;
        state_d    = S_WAIT_A;
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  // State, operand and Moore-output registers. The outputs are decoded from
  // the next state, so each one is a flop that matches the state it enters.
  always_ff @(posedge Clock) begin
    // NOTE: the reset is synchronous. Resetn is only looked at on a clock edge,
    // so it sits inside the clocked branch rather than in the sensitivity list.
    if (!Resetn) begin
      state_q    <= S_LOAD_A;
      dividend_q <= '0;
      divisor_q  <= '0;
      go_q       <= 1'b0;
      valid_q    <= 1'b0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so all flops
      // update together from the values they had before the edge.
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      go_q       <= (state_d == S_GO);
      valid_q    <= (state_d == S_DONE);
      dbz_q      <= (state_d == S_ERR);
      busy_q     <= (state_d != S_LOAD_A);
    end
  end

  assign Dividend    = dividend_q;
  assign Divisor     = divisor_q;
  assign Go          = go_q;
  assign ResultValid = valid_q;
  assign DivByZero   = dbz_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Bench for div_operand_sequencer. The behavioural model tracks the operands
// captured so far, whether a Load press is still held, and the launch/error
// outcome. It is compared with the DUT on every falling edge. Directed steps
// add hand-computed literal checks.
module tb_div_operand_sequencer;

  localparam int WIDTH = 4;

  logic             Clock = 1'b0;
  logic             Resetn;
  logic [WIDTH-1:0] DataIn;
  logic             Load;
  logic             Start;
  logic [WIDTH-1:0] Dividend, Divisor;
  logic             Go, ResultValid, DivByZero, Busy;

  int n_checks = 0;
  int n_fail   = 0;

  div_operand_sequencer #(.WIDTH(WIDTH)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .DataIn     (DataIn),
    .Load       (Load),
    .Start      (Start),
    .Dividend   (Dividend),
    .Divisor    (Divisor),
    .Go         (Go),
    .ResultValid(ResultValid),
    .DivByZero  (DivByZero),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_a, m_b;
  int               m_cnt;     // operands captured in the current sequence (0..2)
  logic             m_held;    // a captured Load press not yet released
  logic             m_go, m_valid, m_err;
  logic             m_live = 1'b0;

  always @(posedge Clock) begin
    m_live = 1'b1;
    if (!Resetn) begin
      m_a = '0; m_b = '0; m_cnt = 0; m_held = 0;
      m_go = 0; m_valid = 0; m_err = 0;
    end else if (m_go) begin
      m_go    = 0;
      m_valid = 1;
    end else if (m_held) begin
      if (!Load) m_held = 0;
    end else if (m_valid || m_err) begin
      if (Load) begin
        m_a = DataIn; m_cnt = 1; m_held = 1; m_valid = 0; m_err = 0;
      end
    end else if (m_cnt < 2) begin
      if (Load) begin
        if (m_cnt == 0) m_a = DataIn;
        else            m_b = DataIn;
        m_cnt++;
        m_held = 1;
      end
    end else if (Start) begin
      if (m_b != 0) m_go  = 1;
      else          m_err = 1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    if (m_live) begin
      check("cyc_dividend", Dividend, m_a);
      check("cyc_divisor", Divisor, m_b);
      check("cyc_go", Go, m_go);
      check("cyc_valid", ResultValid, m_valid);
      check("cyc_divbyzero", DivByZero, m_err);
      check("cyc_busy", Busy, (m_cnt != 0) || m_held);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic load_val(input logic [WIDTH-1:0] v);
    DataIn = v; Load = 1'b1; tick();
    Load = 1'b0; tick();
  endtask

  task automatic do_reset();
    Resetn = 1'b0; tick(); tick();
    Resetn = 1'b1;
  endtask

  int gos;
  logic [WIDTH-1:0] q_v, r_v;

  initial begin
    Resetn = 1'b0; DataIn = '0; Load = 1'b0; Start = 1'b0;

    // 1: reset state, then 13 / 4 launches once and the result follows one edge later.
    do_reset();
    check("reset_busy", Busy, 0);
    check("reset_dividend", Dividend, 0);
    check("reset_go", Go, 0);
    load_val(4'd13);
    load_val(4'd4);
    check("ready_busy", Busy, 1);
    Start = 1'b1; tick();
    check("t1_go", Go, 1);
    check("t1_valid_early", ResultValid, 0);
    Start = 1'b0; tick();
    check("t1_go_drop", Go, 0);
    check("t1_valid", ResultValid, 1);
    q_v = Dividend / Divisor;
    r_v = Dividend % Divisor;
    check("t1_quotient", q_v, 3);
    check("t1_remainder", r_v, 1);

    // 2: 9 / 0 is screened, and a later Load clears the error.
    load_val(4'd9);
    check("t2_valid_cleared", ResultValid, 0);
    load_val(4'd0);
    Start = 1'b1; tick();
    check("t2_divbyzero", DivByZero, 1);
    check("t2_no_go", Go, 0);
    Start = 1'b0; tick();
    check("t2_no_go_later", Go, 0);
    DataIn = 4'd6; Load = 1'b1; tick();
    check("t2_dbz_clear", DivByZero, 0);
    check("t2_dividend6", Dividend, 6);
    Load = 1'b0; tick();

    // 3: a held Load captures once, even if the switches change while it is held.
    do_reset();
    DataIn = 4'd5; Load = 1'b1; tick();
    DataIn = 4'd8;
    repeat (9) tick();
    Load = 1'b0; tick();
    check("t3_dividend", Dividend, 5);
    check("t3_divisor", Divisor, 0);
    check("t3_busy", Busy, 1);
    load_val(4'd3);  // the next press must land in the divisor
    check("t3_second_is_divisor", Divisor, 3);

    // 4 + 5: Load and Start together in READY with 7 / 2, then Start held.
    do_reset();
    load_val(4'd7);
    load_val(4'd2);
    DataIn = 4'd15; Load = 1'b1; Start = 1'b1; tick();
    check("t4_go", Go, 1);
    check("t4_dividend", Dividend, 7);
    check("t4_divisor", Divisor, 2);
    Load = 1'b0;
    gos = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Go) gos++;
    end
    check("t5_no_relaunch", gos, 0);
    check("t5_valid_held", ResultValid, 1);
    Start = 1'b0; tick();

    // A divisor that is zero except for its top bit must still launch.
    load_val(4'd0);
    load_val(4'd8);
    Start = 1'b1; tick();
    check("msb_divisor_go", Go, 1);
    Start = 1'b0; tick();
    check("msb_divisor_valid", ResultValid, 1);

    // 6: a reset during the Go cycle aborts with no pulse afterwards.
    load_val(4'd3);
    load_val(4'd5);
    Start = 1'b1; tick();
    check("t6_go", Go, 1);
    Resetn = 1'b0; tick();
    check("t6_go_killed", Go, 0);
    check("t6_dividend", Dividend, 0);
    check("t6_divisor", Divisor, 0);
    check("t6_valid", ResultValid, 0);
    check("t6_busy", Busy, 0);
    Resetn = 1'b1; Start = 1'b0; tick();
    check("t6_go_after", Go, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
